// File: rtl/commit_trace_tx.sv
// Commit trace transmitter: packs per-cycle writeback/memory/halt strobes into records,
// queues them in a small FIFO and, after halt, streams a fixed summary of performance counters.
module commit_trace_tx #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite,
    input  logic [2:0]  WriteReg,
    input  logic [15:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] MemAddress,
    input  logic [15:0] MemDataIn,
    input  logic [15:0] MemDataOut,
    input  logic        Halt,
    input  logic        ICacheReq,
    input  logic        ICacheHit,
    input  logic        DCacheReq,
    input  logic        DCacheHit,
    output logic        trc_valid,
    input  logic        trc_ready,
    output logic        trc_kind,
    output logic [54:0] trc_data,
    output logic        overflow,
    output logic        done
);

    localparam int REC_W = 55;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NCNT  = 7;
    localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

    // Counter slots in summary order.
    localparam int C_CYCLE = 0;
    localparam int C_INST  = 1;
    localparam int C_DCHIT = 2;
    localparam int C_ICHIT = 3;
    localparam int C_DCREQ = 4;
    localparam int C_ICREQ = 5;
    localparam int C_DROP  = 6;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_SUMMARY,
        S_DONE
    } state_e;

    state_e                        state_q, state_d;
    logic [DEPTH-1:0][REC_W-1:0]   mem_q;
    logic [AW-1:0]                 rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]                   occ_q, occ_d, occ_rem;
    logic                          valid_q, valid_d;
    logic                          kind_q, kind_d;
    logic [REC_W-1:0]              data_q, data_d;
    logic                          ovf_q, ovf_d;
    logic                          done_q, done_d;
    logic [2:0]                    idx_q, idx_d;
    logic [NCNT-1:0][CNT_W-1:0]    perf_q, perf_d;

    logic [REC_W-1:0] rec;
    logic             run, push, xfer, pop, full, push_ok, drop;

    function automatic logic [REC_W-1:0] sum_rec(input logic [2:0] i, input logic [CNT_W-1:0] c);
        return {i, 20'b0, 32'(c)};
    endfunction

    // Fields belonging to an inactive strobe are forced to zero.
    always_comb begin
        rec = {Halt, MemWrite, MemRead, RegWrite,
               RegWrite ? WriteReg : 3'b0,
               RegWrite ? WriteData : 16'b0,
               (MemRead | MemWrite) ? MemAddress : 16'b0,
               MemWrite ? MemDataIn : (MemRead ? MemDataOut : 16'b0)};
    end

    assign run     = (state_q == S_RUN);
    assign push    = run & (RegWrite | MemRead | MemWrite | Halt);
    assign xfer    = valid_q & trc_ready;
    assign pop     = xfer & ~kind_q;
    assign full    = (occ_q == FULL_OCC);
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;
    assign occ_rem = occ_q - (AW + 1)'(pop);
    assign occ_d   = occ_rem + (AW + 1)'(push_ok);
    assign rd_d    = rd_q + AW'(pop);
    assign wr_d    = wr_q + AW'(push_ok);

    always_comb begin
        perf_d = perf_q;
        if (run) begin
            perf_d[C_CYCLE] = perf_q[C_CYCLE] + CNT_W'(1);
            perf_d[C_INST]  = perf_q[C_INST]  + CNT_W'(Halt | RegWrite | MemWrite);
            perf_d[C_DCHIT] = perf_q[C_DCHIT] + CNT_W'(DCacheHit);
            perf_d[C_ICHIT] = perf_q[C_ICHIT] + CNT_W'(ICacheHit);
            perf_d[C_DCREQ] = perf_q[C_DCREQ] + CNT_W'(DCacheReq);
            perf_d[C_ICREQ] = perf_q[C_ICREQ] + CNT_W'(ICacheReq);
            perf_d[C_DROP]  = perf_q[C_DROP]  + CNT_W'(drop);
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        kind_d  = kind_q;
        data_d  = data_q;
        idx_d   = idx_q;
        done_d  = done_q;
        ovf_d   = ovf_q | drop;
        case (state_q)
            S_RUN, S_DRAIN: begin
                valid_d = (occ_d != '0);
                kind_d  = 1'b0;
                // Head after this edge: surviving entry, or the new record bypassed into an empty FIFO.
                if (occ_rem != '0)
                    data_d = mem_q[rd_d];
                else if (push_ok)
                    data_d = rec;
                if (run && Halt)
                    state_d = S_DRAIN;
                if (state_q == S_DRAIN && occ_q == '0) begin
                    state_d = S_SUMMARY;
                    valid_d = 1'b1;
                    kind_d  = 1'b1;
                    idx_d   = 3'd0;
                    data_d  = sum_rec(3'd0, perf_q[0]);
                end
            end
            S_SUMMARY: begin
                if (xfer) begin
                    if (idx_q == 3'(NCNT - 1)) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        data_d = sum_rec(idx_q + 3'd1, perf_q[idx_q + 3'd1]);
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_q] <= rec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            rd_q    <= '0;
            wr_q    <= '0;
            occ_q   <= '0;
            valid_q <= 1'b0;
            kind_q  <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= 3'd0;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
            kind_q  <= kind_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            perf_q  <= perf_d;
        end
    end

    assign trc_valid = valid_q;
    assign trc_kind  = kind_q;
    assign trc_data  = data_q;
    assign overflow  = ovf_q;
    assign done      = done_q;

endmodule

// File: tb/tb_commit_trace_tx.sv
// Randomized bench for commit_trace_tx against a queue-based reference model of the trace stream.
module tb_commit_trace_tx;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWrite, MemRead, MemWrite, Halt;
    logic [2:0]  WriteReg;
    logic [15:0] WriteData, MemAddress, MemDataIn, MemDataOut;
    logic        ICacheReq, ICacheHit, DCacheReq, DCacheHit;
    logic        trc_valid, trc_ready, trc_kind, overflow, done;
    logic [54:0] trc_data;

    always #5 clk = ~clk;

    commit_trace_tx #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemAddress(MemAddress),
        .MemDataIn(MemDataIn), .MemDataOut(MemDataOut), .Halt(Halt),
        .ICacheReq(ICacheReq), .ICacheHit(ICacheHit),
        .DCacheReq(DCacheReq), .DCacheHit(DCacheHit),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_kind(trc_kind),
        .trc_data(trc_data), .overflow(overflow), .done(done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_RUN, M_DRAIN, M_SUM, M_DONE} mph_e;
    mph_e        ph;
    logic [54:0] q[$];
    logic [31:0] m_cnt[7];
    bit          m_ovf;
    int          m_idx;

    task automatic m_reset();
        q.delete();
        for (int i = 0; i < 7; i++) m_cnt[i] = '0;
        m_ovf = 1'b0;
        m_idx = 0;
        ph    = M_RUN;
    endtask

    function automatic logic [54:0] exp_rec();
        logic [2:0]  wr;
        logic [15:0] wd, ma, md;
        wr = RegWrite ? WriteReg : 3'd0;
        wd = RegWrite ? WriteData : 16'd0;
        ma = (MemRead || MemWrite) ? MemAddress : 16'd0;
        md = MemWrite ? MemDataIn : (MemRead ? MemDataOut : 16'd0);
        return {Halt, MemWrite, MemRead, RegWrite, wr, wd, ma, md};
    endfunction

    task automatic m_edge();
        bit pop, full;
        case (ph)
            M_RUN: begin
                full = (q.size() == DEPTH);
                pop  = (q.size() > 0) && trc_ready;
                m_cnt[0]++;
                if (Halt || RegWrite || MemWrite) m_cnt[1]++;
                if (DCacheHit) m_cnt[2]++;
                if (ICacheHit) m_cnt[3]++;
                if (DCacheReq) m_cnt[4]++;
                if (ICacheReq) m_cnt[5]++;
                if (pop) void'(q.pop_front());
                if (RegWrite || MemRead || MemWrite || Halt) begin
                    if (!full || pop) q.push_back(exp_rec());
                    else begin
                        m_ovf = 1'b1;
                        m_cnt[6]++;
                    end
                end
                if (Halt) ph = M_DRAIN;
            end
            M_DRAIN: begin
                if (q.size() == 0) begin
                    ph    = M_SUM;
                    m_idx = 0;
                end else if (trc_ready) void'(q.pop_front());
            end
            M_SUM: begin
                if (trc_ready) begin
                    if (m_idx == 6) ph = M_DONE;
                    else m_idx++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic m_check();
        bit          ev;
        logic [54:0] ed;
        logic [2:0]  i3;
        ev = 1'b0;
        ed = '0;
        if ((ph == M_RUN || ph == M_DRAIN) && q.size() > 0) begin
            ev = 1'b1;
            ed = q[0];
        end else if (ph == M_SUM) begin
            ev = 1'b1;
            i3 = 3'(m_idx);
            ed = {i3, 20'b0, m_cnt[m_idx]};
        end
        chk("valid", trc_valid, ev);
        if (ev) begin
            chk("kind", trc_kind, (ph == M_SUM));
            chk("data", trc_data, ed);
        end
        chk("overflow", overflow, m_ovf);
        chk("done", done, (ph == M_DONE));
    endtask

    // Inputs are driven #1 after posedge; outputs checked on negedge.
    task automatic step();
        @(negedge clk);
        if (rst) m_reset();
        m_check();
        if (!rst) m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWrite = 0; MemRead = 0; MemWrite = 0; Halt = 0;
        ICacheReq = 0; ICacheHit = 0; DCacheReq = 0; DCacheHit = 0;
    endtask

    task automatic rand_in(input int pct);
        RegWrite   = ($urandom % 100) < pct;
        MemRead    = ($urandom % 100) < pct / 2;
        MemWrite   = ($urandom % 100) < pct / 2;
        Halt       = 1'b0;
        WriteReg   = 3'($urandom);
        WriteData  = 16'($urandom);
        MemAddress = 16'($urandom);
        MemDataIn  = 16'($urandom);
        MemDataOut = 16'($urandom);
        ICacheReq  = $urandom % 2;
        ICacheHit  = $urandom % 2;
        DCacheReq  = $urandom % 2;
        DCacheHit  = $urandom % 2;
    endtask

    task automatic store_cycle();
        rand_in(0);
        MemWrite = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
    endtask

    logic [31:0] got_sum[7];
    int          first_idx;

    task automatic run_to_done(input int limit);
        int n;
        n = 0;
        first_idx = -1;
        for (int i = 0; i < 7; i++) got_sum[i] = 32'hDEAD_BEEF;
        while (ph != M_DONE && n < limit) begin
            if (trc_valid && trc_kind) begin
                got_sum[trc_data[54:52]] = trc_data[31:0];
                if (first_idx < 0) first_idx = int'(trc_data[54:52]);
            end
            rand_in(60);
            trc_ready = ($urandom % 3) != 0;
            step();
            n++;
        end
        chk("done_reached", done, 1'b1);
        repeat (2) step();
    endtask

    task automatic halt_cycle();
        rand_in(50);
        Halt = 1'b1;
        step();
    endtask

    initial begin : wdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [54:0] t2exp;
        idle();
        WriteReg = 0; WriteData = 0; MemAddress = 0; MemDataIn = 0; MemDataOut = 0;
        trc_ready = 1'b0;
        m_reset();
        #1 rst = 1'b1;

        // T1: reset held with strobes active
        RegWrite = 1; MemWrite = 1; Halt = 1; ICacheReq = 1; DCacheHit = 1;
        repeat (3) step();
        chk("rst_valid", trc_valid, 1'b0);
        chk("rst_kind", trc_kind, 1'b0);
        chk("rst_data", trc_data, 55'd0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        idle();
        step();

        // T2: load-to-reg record
        RegWrite = 1; WriteReg = 3'd3; WriteData = 16'hBEEF;
        MemRead = 1; MemAddress = 16'h0040; MemDataOut = 16'hBEEF; MemDataIn = 16'h1234;
        step();
        idle();
        t2exp = {4'b0011, 3'd3, 16'hBEEF, 16'h0040, 16'hBEEF};
        chk("t2_valid", trc_valid, 1'b1);
        chk("t2_rec", trc_data, t2exp);
        trc_ready = 1'b1;
        repeat (3) step();

        // T4: full FIFO, push with pop in the same cycle
        trc_ready = 1'b0;
        repeat (DEPTH) begin store_cycle(); step(); end
        trc_ready = 1'b1;
        store_cycle();
        step();
        chk("t4_ovf", overflow, 1'b0);
        idle();
        repeat (2) step();

        // Random traffic with intermittent backpressure
        for (int c = 0; c < 400; c++) begin
            rand_in(55);
            trc_ready = (c % 50 < 10) ? 1'b0 : (($urandom % 4) != 0);
            step();
        end
        halt_cycle();
        run_to_done(300);

        // T5: 3 reg writes, 1 store, halt, consumer always ready
        do_reset();
        trc_ready = 1'b1;
        repeat (3) begin rand_in(0); RegWrite = 1'b1; step(); end
        store_cycle();
        step();
        idle();
        Halt = 1'b1;
        step();
        run_to_done(100);
        chk("t5_cycles", got_sum[0], 32'd5);
        chk("t5_inst", got_sum[1], 32'd5);
        chk("t5_drop", got_sum[6], 32'd0);

        // T3: backpressure, 6 stores into a 4-deep FIFO
        do_reset();
        trc_ready = 1'b0;
        repeat (6) begin store_cycle(); step(); end
        idle();
        chk("t3_ovf", overflow, 1'b1);
        trc_ready = 1'b1;
        halt_cycle();
        run_to_done(100);
        chk("t3_drop", got_sum[6], 32'd2);

        // T6: reset in the middle of the summary
        do_reset();
        for (int c = 0; c < 30; c++) begin
            rand_in(50);
            trc_ready = $urandom % 2;
            step();
        end
        halt_cycle();
        for (int n = 0; n < 100 && !(ph == M_SUM && m_idx == 3); n++) begin
            rand_in(50);
            trc_ready = $urandom % 2;
            step();
        end
        chk("t6_at_idx3", trc_data[54:52], 3'd3);
        rst = 1'b1;
        #1;
        chk("t6_valid", trc_valid, 1'b0);
        chk("t6_done", done, 1'b0);
        step();
        rst = 1'b0;
        idle();
        for (int c = 0; c < 20; c++) begin
            rand_in(50);
            trc_ready = 1'b1;
            step();
        end
        halt_cycle();
        run_to_done(200);
        chk("t6_first_idx", 64'(first_idx), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
